// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_SB, OP_SH, OP_SW, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_DONE, S_ERR
  } state_e;

  typedef logic [1:0] size_t;
  localparam size_t SZ_B = 2'd0;
  localparam size_t SZ_H = 2'd1;
  localparam size_t SZ_W = 2'd2;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic size_t op_size(input op_e op);
    case (op)
      OP_SB, OP_LB, OP_LBU: return SZ_B;
      OP_SH, OP_LH, OP_LHU: return SZ_H;
      default:              return SZ_W;
    endcase
  endfunction

  function automatic logic op_is_load(input op_e op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_signed(input op_e op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/lsu_mem_if_load_align.sv
// Selects the addressed byte/halfword of a read word and extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane selection and sign/zero extension
  always_comb begin
    byte_v = rdata[{offset, 3'b000} +: 8];
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    result = {{24{sign_ext & byte_v[7]}}, byte_v};
      SZ_H:    result = {{16{sign_ext & half_v[15]}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: one bus transaction per decoded load/store strobe.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sb,
  input  logic        sh,
  input  logic        sw,
  input  logic        lb,
  input  logic        lh,
  input  logic        lw,
  input  logic        lbu,
  input  logic        lhu,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic        timeout,
  output logic [31:0] rdata_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  op_e         op_in, op_q;
  logic [1:0]  off_q;
  logic [CNT_W-1:0] cnt_q;
  logic        to_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic [31:0] maddr_q, mwdata_q;
  logic [3:0]  be_q;

  logic [7:0]  flags;
  logic        one_hot, accept, misalign_in, last_cycle;
  size_t       size_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, align_result;

  assign flags       = {lhu, lbu, lw, lh, lb, sw, sh, sb};
  assign one_hot     = (flags != '0) && ((flags & (flags - 8'd1)) == '0);
  assign accept      = (state_q == S_IDLE) && start && one_hot;
  assign size_in     = op_size(op_in);
  assign misalign_in = ((size_in == SZ_H) && addr[0]) ||
                       ((size_in == SZ_W) && (addr[1:0] != 2'b00));
  assign last_cycle  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Map the one-hot strobe vector onto the op enum (only used when one-hot)
  always_comb begin
    op_in = OP_SB;
    for (int unsigned i = 0; i < 8; i++) begin
      if (flags[i]) op_in = op_e'(3'(i));
    end
  end

  // Lane enables and lane-replicated store data for the incoming op
  always_comb begin
    case (size_in)
      SZ_B: begin
        be_in    = BE_BYTE << addr[1:0];
        wdata_in = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be_in    = addr[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_in = {2{wdata[15:0]}};
      end
      default: begin
        be_in    = BE_WORD;
        wdata_in = wdata;
      end
    endcase
    if (op_is_load(op_in)) wdata_in = '0;
  end

  lsu_load_align u_align (
    .rdata    (mem_rdata),
    .offset   (off_q),
    .size     (op_size(op_q)),
    .sign_ext (op_signed(op_q)),
    .result   (align_result)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; an ack on the final counted cycle takes priority over timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = misalign_in ? S_ERR : S_REQ;
      S_REQ:  if (mem_ack || last_cycle) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status and bus-request outputs decoded from state
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE) || (state_q == S_ERR);
    misalign = (state_q == S_ERR);
    timeout  = (state_q == S_DONE) && to_q;
    mem_req  = (state_q == S_REQ);
  end

  // Request capture, timeout counter and load result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_SB;
      off_q    <= '0;
      cnt_q    <= '0;
      to_q     <= 1'b0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      be_q     <= '0;
      mwdata_q <= '0;
    end else begin
      cnt_q <= (state_q == S_REQ) ? cnt_q + CNT_W'(1) : '0;
      if (accept) begin
        to_q <= 1'b0;
        if (!misalign_in) begin
          op_q     <= op_in;
          off_q    <= addr[1:0];
          we_q     <= !op_is_load(op_in);
          maddr_q  <= {addr[31:2], 2'b00};
          be_q     <= be_in;
          mwdata_q <= wdata_in;
        end
      end
      if (state_q == S_REQ) begin
        if (mem_ack) begin
          if (op_is_load(op_q)) rdata_q <= align_result;
        end else if (last_cycle) begin
          to_q <= 1'b1;
        end
      end
    end
  end

  assign rdata_out = rdata_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_be    = be_q;
  assign mem_wdata = mwdata_q;

endmodule
